// File: rtl/cic_comb_decim.sv
// CIC decimator back end: decimates an accumulator stream and applies pipelined comb stages,
// delivering results through a one-entry valid/ready buffer. Optional macro: CIC_GAIN_SHIFT_EN.
module cic_comb_decim #(
   parameter int unsigned width_p  = 16,
   parameter int unsigned decim_p  = 4,
   parameter int unsigned stages_p = 1,
   parameter int unsigned shift_p  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic [width_p-1:0] in_data,
   input  logic               in_valid,
   output logic [width_p-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               overrun
);

   localparam int unsigned   W          = width_p;
   localparam int unsigned   PW         = (decim_p > 1) ? $clog2(decim_p) : 1;
   localparam int unsigned   CW         = $clog2(stages_p + 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(decim_p - 1);
   localparam logic [CW-1:0] PRIME_CNT  = CW'(stages_p);

   if (decim_p < 2) begin : g_bad_decim
      $error("cic_comb_decim: decim_p must be >= 2");
   end
   if (stages_p < 1 || stages_p > 4) begin : g_bad_stages
      $error("cic_comb_decim: stages_p must be 1..4");
   end
   if (shift_p >= width_p) begin : g_bad_shift
      $error("cic_comb_decim: shift_p must be < width_p");
   end

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } state_e;

   state_e                   state_q, state_d;
   logic [PW-1:0]            phase_q, phase_d;
   // Index 0 is the strobe-sampled input; index k is the output of comb stage k.
   logic [stages_p:0][W-1:0] stg_q, stg_d;
   logic [stages_p:0]        vld_q, vld_d;
   logic [stages_p:1][W-1:0] dly_q, dly_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [W-1:0]             out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;
   logic                     overrun_q, overrun_d;
   logic                     strobe_c;
   logic [W-1:0]             load_c;

`ifdef CIC_GAIN_SHIFT_EN
   localparam logic [W-1:0] RND = (shift_p > 0) ? (W'(1) << ((shift_p > 0) ? shift_p - 1 : 0)) : '0;
   logic [W-1:0] rnd_c;

   // Round half-up then arithmetic shift; the rounding add wraps.
   always_comb begin
      rnd_c  = stg_q[stages_p] + RND;
      load_c = W'($signed(rnd_c) >>> shift_p);
   end
`else
   assign load_c = stg_q[stages_p];
`endif

   // Next-state: phase, comb pipeline, prime FSM and output buffer.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      stg_d       = stg_q;
      vld_d       = '0;
      dly_d       = dly_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      overrun_d   = overrun_q;

      strobe_c = in_valid && (phase_q == PHASE_LAST);
      if (in_valid) begin
         phase_d = strobe_c ? '0 : phase_q + PW'(1);
      end

      vld_d[0] = strobe_c;
      if (strobe_c) begin
         stg_d[0] = in_data;
      end

      for (int unsigned k = 1; k <= stages_p; k++) begin
         vld_d[k] = vld_q[k-1];
         if (vld_q[k-1]) begin
            stg_d[k] = stg_q[k-1] - dly_q[k];
            dly_d[k] = stg_q[k-1];
         end
      end

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (vld_q[stages_p]) begin
         case (state_q)
            PRIME: begin
               cnt_d = cnt_q + CW'(1);
               if ((cnt_q + CW'(1)) == PRIME_CNT) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (!out_valid_q || out_ready) begin
                  out_data_d  = load_c;
                  out_valid_d = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (clr) begin
         state_d     = PRIME;
         phase_d     = '0;
         stg_d       = '0;
         vld_d       = '0;
         dly_d       = '0;
         cnt_d       = '0;
         out_data_d  = '0;
         out_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= PRIME;
         phase_q     <= '0;
         stg_q       <= '0;
         vld_q       <= '0;
         dly_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         stg_q       <= stg_d;
         vld_q       <= vld_d;
         dly_q       <= dly_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comb_decim.sv
// Self-checking bench for cic_comb_decim: one-stage and two-stage instances share stimulus and
// are compared every cycle against a sample-level CIC reference model.
module tb_cic_comb_decim;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst, clr, in_valid, out_ready;
   logic [15:0] in_data;
   logic [15:0] od1, od2;
   logic        ov1, ov2, or1, or2;

   always #5 clk = ~clk;

   cic_comb_decim #(.width_p(16), .decim_p(D), .stages_p(1), .shift_p(2)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
      .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .overrun(or1));

   cic_comb_decim #(.width_p(16), .decim_p(D), .stages_p(2), .shift_p(2)) dut2 (
      .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
      .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .overrun(or2));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: decimated samples in a list; result j is the s-th finite difference
   // with zero history, the first s results of each run are discarded.
   int unsigned e, vcnt;
   logic [15:0] hist[$];
   bit          m_pend[2];
   int unsigned m_due[2], m_idx[2];
   logic [15:0] m_val[2], m_data[2];
   bit          m_valid[2], m_ovr[2];

   function automatic logic [15:0] comb_ref(input int s, input int j);
      int acc = 0;
      int c = 1;
      for (int i = 0; i <= s; i++) begin
         if (j - i >= 0) acc += ((i % 2) != 0 ? -c : c) * int'(hist[j-i]);
         c = c * (s - i) / (i + 1);
      end
      return 16'(acc);
   endfunction

   task automatic model_reset();
      e = 0;
      vcnt = 0;
      hist.delete();
      for (int m = 0; m < 2; m++) begin
         m_pend[m] = 0; m_due[m] = 0; m_idx[m] = 0; m_val[m] = '0;
         m_data[m] = '0; m_valid[m] = 0; m_ovr[m] = 0;
      end
   endtask

   task automatic model_edge(input bit iv, input logic [15:0] din, input bit rdy, input bit cl);
      bit nv;
      int j;
      if (cl) begin
         model_reset();
         return;
      end
      e++;
      for (int m = 0; m < 2; m++) begin
         nv = m_valid[m] && !rdy;
         if (m_pend[m] && m_due[m] == e) begin
            m_pend[m] = 0;
            if (m_idx[m] >= unsigned'(m + 1)) begin
               if (!m_valid[m] || rdy) begin
                  m_data[m] = m_val[m];
                  nv = 1;
               end else begin
                  m_ovr[m] = 1;
               end
            end
         end
         m_valid[m] = nv;
      end
      if (iv) begin
         vcnt++;
         if (vcnt == D) begin
            vcnt = 0;
            hist.push_back(din);
            j = hist.size() - 1;
            for (int m = 0; m < 2; m++) begin
               m_pend[m] = 1;
               m_due[m]  = e + unsigned'(m) + 2;
               m_val[m]  = comb_ref(m + 1, j);
               m_idx[m]  = unsigned'(j);
            end
         end
      end
   endtask

   task automatic check_model();
      chk("s1_valid",   32'(ov1), 32'(m_valid[0]));
      chk("s1_data",    32'(od1), 32'(m_data[0]));
      chk("s1_overrun", 32'(or1), 32'(m_ovr[0]));
      chk("s2_valid",   32'(ov2), 32'(m_valid[1]));
      chk("s2_data",    32'(od2), 32'(m_data[1]));
      chk("s2_overrun", 32'(or2), 32'(m_ovr[1]));
   endtask

   task automatic tick(input bit iv, input logic [15:0] din, input bit rdy, input bit cl);
      in_valid  = iv;
      in_data   = din;
      out_ready = rdy;
      clr       = cl;
      @(posedge clk);
      model_edge(iv, din, rdy, cl);
      #1;
      check_model();
   endtask

   logic [15:0] xacc;

   task automatic ramp(input logic [15:0] step, input int n, input bit rdy);
      for (int i = 0; i < n; i++) begin
         xacc = xacc + step;
         tick(1'b1, xacc, rdy, 1'b0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_valid",   32'(ov1), 32'd0);
      chk("rst_data",    32'(od1), 32'd0);
      chk("rst_overrun", 32'(or1), 32'd0);
      chk("rst_phase",   32'(dut.phase_q), 32'd0);
      chk("rst_valid2",  32'(ov2), 32'd0);
      rst = 1'b0;
      xacc = '0;
   endtask

   typedef struct {
      bit          iv;
      logic [15:0] din;
      bit          rdy;
      bit          ev;
      logic [15:0] ed;
      bit          eo;
   } vec_t;

   vec_t tbl[14];
   int   nres;

   initial begin
      // Wrap-around ramp of step 0x3000: strobes at edges 3, 7, 11; first result primed away.
      for (int i = 0; i < 14; i++) begin
         tbl[i].iv  = 1'b1;
         tbl[i].din = 16'(32'h3000 * (i + 1));
         tbl[i].rdy = 1'b1;
         tbl[i].ev  = (i == 9) || (i == 13);
         tbl[i].ed  = (i >= 9) ? 16'hC000 : 16'h0000;
         tbl[i].eo  = 1'b0;
      end

      do_reset();
      for (int i = 0; i < 14; i++) begin
         tick(tbl[i].iv, tbl[i].din, tbl[i].rdy, 1'b0);
         chk($sformatf("vec%0d_valid", i),   32'(ov1), 32'(tbl[i].ev));
         chk($sformatf("vec%0d_data", i),    32'(od1), 32'(tbl[i].ed));
         chk($sformatf("vec%0d_overrun", i), 32'(or1), 32'(tbl[i].eo));
      end

      // Constant input 3 with ready: results of 12.
      do_reset();
      ramp(16'd3, 9, 1'b1);
      chk("c3_primed", 32'(ov1), 32'd0);
      ramp(16'd3, 1, 1'b1);
      chk("c3_valid", 32'(ov1), 32'd1);
      chk("c3_data",  32'(od1), 32'd12);

      // Backpressure: hold first result, drop the next, sticky overrun, clr.
      do_reset();
      ramp(16'd3, 10, 1'b0);
      chk("bp_first_valid", 32'(ov1), 32'd1);
      chk("bp_first_data",  32'(od1), 32'd12);
      chk("bp_first_ovr",   32'(or1), 32'd0);
      ramp(16'd3, 4, 1'b0);
      chk("bp_drop_ovr",   32'(or1), 32'd1);
      chk("bp_drop_data",  32'(od1), 32'd12);
      tick(1'b0, 16'd0, 1'b1, 1'b0);
      chk("bp_accept_valid", 32'(ov1), 32'd0);
      chk("bp_accept_ovr",   32'(or1), 32'd1);
      tick(1'b0, 16'd0, 1'b0, 1'b1);
      chk("bp_clr_ovr", 32'(or1), 32'd0);
      xacc = '0;
      ramp(16'd3, 6, 1'b1);
      chk("bp_clr_primed", 32'(ov1), 32'd0);
      ramp(16'd3, 4, 1'b1);
      chk("bp_clr_run_data", 32'(od1), 32'd12);

      // Toggling in_valid: strobe every 8 cycles, same results.
      do_reset();
      nres = 0;
      for (int k = 0; k < 34; k++) begin
         if (k % 2 == 0) xacc = xacc + 16'd3;
         tick(k % 2 == 0, xacc, 1'b1, 1'b0);
         if (ov1) begin
            nres++;
            chk("tog_data", 32'(od1), 32'd12);
         end
      end
      chk("tog_count", 32'(nres), 32'd3);

      // Two stages, unit ramp: two results discarded, then zeros, latency one edge longer.
      do_reset();
      ramp(16'd1, 14, 1'b1);
      chk("s2_before", 32'(ov2), 32'd0);
      ramp(16'd1, 1, 1'b1);
      chk("s2_first_valid", 32'(ov2), 32'd1);
      chk("s2_first_data",  32'(od2), 32'd0);

      // Asynchronous reset mid-stream with a buffered result.
      do_reset();
      ramp(16'd3, 11, 1'b0);
      chk("ar_pre_valid", 32'(ov1), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid",   32'(ov1), 32'd0);
      chk("ar_data",    32'(od1), 32'd0);
      chk("ar_overrun", 32'(or1), 32'd0);
      chk("ar_phase",   32'(dut.phase_q), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      xacc = '0;
      ramp(16'd3, 6, 1'b1);
      chk("ar_primed", 32'(ov1), 32'd0);
      ramp(16'd3, 4, 1'b1);
      chk("ar_run_valid", 32'(ov1), 32'd1);
      chk("ar_run_data",  32'(od1), 32'd12);

      // Randomized traffic against the model.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         tick(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, ($urandom % 300) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
